dmem_arbiter: RTL and testbench

Two-port arbiter sharing the single-port 32-bit data RAM (byte-addressed at the ports, word-indexed at the RAM) between the CPU memory stage (port 0) and the UART program-loader/IO master (port 1). Grants at most one access per clock, round-robin with optional short locks, and returns read data with a tagged valid pulse one cycle after grant. Sits between the requesters and the data RAM; the RAM itself is outside this block.

---
 rtl/dmem_pkg.sv | 23 ++
 rtl/dmem_arbiter_if.sv | 44 ++++
 rtl/dmem_rr_pick.sv | 35 +++
 rtl/dmem_arbiter.sv | 128 ++++++++++++
 tb/tb_dmem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dmem_pkg
// Brief    : Shared constants and state encoding for the data-RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package dmem_pkg;

  // Default RAM word-address width (16K words of 32 bits)
  localparam int c_addr_w = 14;

  // Port indices: CPU memory stage and UART loader/IO master
  localparam int c_port0 = 0;
  localparam int c_port1 = 1;

  // Arbiter state: free round-robin or held by a locking requester
  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter_if
// Brief    : Requester and RAM-side signals of the two-port data-RAM arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface dmem_arbiter_if
  import dmem_pkg::*;
#(
  parameter int ADDR_W = c_addr_w
);
  // Requester side
  logic              req0, req1;
  logic              we0, we1;
  logic              lock0, lock1;
  logic [31:0]       addr0, addr1;
  logic [31:0]       wdata0, wdata1;
  logic              gnt0, gnt1;
  logic              rvalid0, rvalid1;
  logic [31:0]       rdata;
  logic              err0, err1;
  // RAM side
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_din;
  logic [31:0]       ram_dout;

  // Environment view: requesters plus the RAM
  modport master (
    output req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1,
    input  ram_we, ram_addr, ram_din,
    output ram_dout
  );

  // Arbiter view
  modport slave (
    input  req0, req1, we0, we1, lock0, lock1, addr0, addr1, wdata0, wdata1,
    output gnt0, gnt1, rvalid0, rvalid1, rdata, err0, err1,
    output ram_we, ram_addr, ram_din,
    input  ram_dout
  );
endinterface
`default_nettype wire

// File: rtl/dmem_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rr_pick
// Brief    : Combinational 2-way round-robin pick with lock-owner override.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_rr_pick
  import dmem_pkg::*;
(
  input  wire logic [1:0] i_req,
  input  wire logic       i_last,
  input  wire logic       i_owner,
  input  wire logic       i_locked,
  output logic [1:0]      o_pick
);

  // While locked only the owner can win; otherwise a lone requester wins and
  // a tie goes to the port that was not granted most recently.
  always_comb begin
    o_pick = 2'b00;
    if (i_locked) begin
      o_pick[i_owner] = i_req[i_owner];
    end else if (i_req == 2'b11) begin
      if (i_last == 1'(c_port1)) begin
        o_pick[c_port0] = 1'b1;
      end else begin
        o_pick[c_port1] = 1'b1;
      end
    end else begin
      o_pick = i_req;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Shares the single-port data RAM between the CPU (port 0) and the
//            UART loader (port 1); one access per clock, round-robin with
//            bounded locks, read data tagged to its port one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W   = c_addr_w,
  parameter int MAX_LOCK = 4
)
(
  input  wire logic     clk,
  input  wire logic     rst,
  dmem_arbiter_if.slave bus
);

  // Value of lock_cnt at the grant that uses up the lock budget
  localparam logic [3:0] c_cnt_last = 4'(MAX_LOCK - 2);

  arb_state_t  r_state, w_state_nxt;
  logic        r_last, w_last_nxt;
  logic        r_owner, w_owner_nxt;
  logic [3:0]  r_lock_cnt, w_lock_cnt_nxt;
  logic [1:0]  r_rd_tag, w_rd_tag_nxt;
  logic [1:0]  r_err, w_err_nxt;

  logic [1:0]  w_pick;
  logic [1:0]  w_gnt;
  logic        w_any;
  logic        w_sel;
  logic        w_we;
  logic        w_lock;
  logic        w_bad;
  logic        w_owner_req;
  logic        w_owner_lock;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;

  dmem_rr_pick u_pick (
    .i_req    ({bus.req1, bus.req0}),
    .i_last   (r_last),
    .i_owner  (r_owner),
    .i_locked (r_state == ST_LOCKED),
    .o_pick   (w_pick)
  );

  // Grant qualification and winner mux; with no grant port 0 drives the RAM bus
  always_comb begin
    w_gnt        = rst ? 2'b00 : w_pick;
    w_any        = |w_gnt;
    w_sel        = w_gnt[1];
    w_addr       = w_sel ? bus.addr1  : bus.addr0;
    w_wdata      = w_sel ? bus.wdata1 : bus.wdata0;
    w_we         = w_sel ? bus.we1    : bus.we0;
    w_lock       = w_sel ? bus.lock1  : bus.lock0;
    w_bad        = (w_addr[1:0] != 2'b00) || (w_addr[31:ADDR_W+2] != '0);
    w_owner_req  = r_owner ? bus.req1  : bus.req0;
    w_owner_lock = r_owner ? bus.lock1 : bus.lock0;
  end

  // Next-state logic: lock entry/exit, round-robin history, response tags
  always_comb begin
    w_state_nxt    = r_state;
    w_owner_nxt    = r_owner;
    w_lock_cnt_nxt = r_lock_cnt;
    w_last_nxt     = w_any ? w_sel : r_last;
    w_rd_tag_nxt   = w_gnt & {2{~w_we & ~w_bad}};
    w_err_nxt      = w_gnt & {2{w_bad}};
    case (r_state)
      ST_IDLE: begin
        if (w_any && w_lock && (MAX_LOCK > 1)) begin
          w_state_nxt    = ST_LOCKED;
          w_owner_nxt    = w_sel;
          w_lock_cnt_nxt = 4'd0;
        end
      end
      ST_LOCKED: begin
        // Owner is granted whenever it requests, so req doubles as "granted"
        if (!w_owner_req || !w_owner_lock || (r_lock_cnt >= c_cnt_last)) begin
          w_state_nxt    = ST_IDLE;
          w_lock_cnt_nxt = 4'd0;
        end else begin
          w_lock_cnt_nxt = r_lock_cnt + 4'd1;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_lock_cnt_nxt = 4'd0;
      end
    endcase
  end

  // Arbiter state register; reset drops any lock and pending responses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_last     <= 1'b1;
      r_owner    <= 1'b0;
      r_lock_cnt <= 4'd0;
      r_rd_tag   <= 2'b00;
      r_err      <= 2'b00;
    end else begin
      r_state    <= w_state_nxt;
      r_last     <= w_last_nxt;
      r_owner    <= w_owner_nxt;
      r_lock_cnt <= w_lock_cnt_nxt;
      r_rd_tag   <= w_rd_tag_nxt;
      r_err      <= w_err_nxt;
    end
  end

  assign bus.gnt0     = w_gnt[0];
  assign bus.gnt1     = w_gnt[1];
  assign bus.ram_we   = w_any & w_we & ~w_bad;
  assign bus.ram_addr = w_addr[ADDR_W+1:2];
  assign bus.ram_din  = w_wdata;
  assign bus.rvalid0  = r_rd_tag[0];
  assign bus.rvalid1  = r_rd_tag[1];
  assign bus.err0     = r_err[0];
  assign bus.err1     = r_err[1];
  assign bus.rdata    = (|r_rd_tag) ? bus.ram_dout : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Brief    : Scoreboard bench for dmem_arbiter with a behavioural RAM and a
//            grant/lock reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;
  import dmem_pkg::*;

  localparam int ADDR_W   = 14;
  localparam int MAX_LOCK = 4;
  localparam int NWORDS   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_LOCK(MAX_LOCK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    int          cyc;
    int          port;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] mem     [0:NWORDS-1];
  logic [31:0] ref_mem [0:NWORDS-1];
  int          checks = 0;
  int          errors = 0;
  int          cyc    = 0;

  bit          p_req   [2];
  bit          p_we    [2];
  bit          p_lock  [2];
  logic [31:0] p_addr  [2];
  logic [31:0] p_wdata [2];

  int m_last  = 1;
  int m_owner = -1;
  int m_held  = 0;
  int m_win   = -1;
  int dut_win = -1;
  int pat [8];

  function automatic logic [31:0] init_val(int i);
    if (i == 0) return 32'h1111_1111;
    if (i == 4) return 32'hDEAD_BEEF;
    return 32'h5000_0000 + 32'(i) * 32'h0001_0203;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // Behavioural single-port RAM, one-cycle read latency, read-old-data
  initial begin
    logic [31:0] rd;
    for (int i = 0; i < NWORDS; i++) mem[i] = init_val(i);
    bus.ram_dout = 32'h0;
    forever begin
      @(posedge clk);
      rd = mem[bus.ram_addr];
      if (bus.ram_we === 1'b1) mem[bus.ram_addr] = bus.ram_din;
      bus.ram_dout <= rd;
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: responses due this cycle are popped; otherwise outputs must be quiet
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (q.size() > 0 && q[0].cyc == cyc - 1) begin
        e = q.pop_front();
        chk("rvalid0", bus.rvalid0, 32'(e.port == 0 && e.rd));
        chk("rvalid1", bus.rvalid1, 32'(e.port == 1 && e.rd));
        chk("err0", bus.err0, 32'(e.port == 0 && e.err));
        chk("err1", bus.err1, 32'(e.port == 1 && e.err));
        chk("rdata", bus.rdata, e.rd ? e.data : 32'h0);
      end else begin
        chk("quiet_flags", {bus.rvalid1, bus.rvalid0, bus.err1, bus.err0}, 32'h0);
        chk("quiet_rdata", bus.rdata, 32'h0);
      end
    end
  end

  task automatic set_port(int p, bit req, bit we, bit lock, logic [31:0] addr, logic [31:0] wd);
    p_req[p] = req; p_we[p] = we; p_lock[p] = lock; p_addr[p] = addr; p_wdata[p] = wd;
  endtask

  task automatic idle_all();
    set_port(0, 0, 0, 0, 32'h0, 32'h0);
    set_port(1, 0, 0, 0, 32'h0, 32'h0);
  endtask

  task automatic drive();
    bus.req0 = p_req[0];   bus.req1 = p_req[1];
    bus.we0 = p_we[0];     bus.we1 = p_we[1];
    bus.lock0 = p_lock[0]; bus.lock1 = p_lock[1];
    bus.addr0 = p_addr[0]; bus.addr1 = p_addr[1];
    bus.wdata0 = p_wdata[0]; bus.wdata1 = p_wdata[1];
  endtask

  // Reference model: who should win, what the RAM sees, what comes back
  task automatic model_eval();
    int          win;
    int          w;
    bit          bad;
    logic [31:0] a;
    exp_t        e;
    win = -1;
    if (m_owner >= 0) begin
      if (p_req[m_owner]) win = m_owner;
    end else if (p_req[0] && p_req[1]) begin
      win = (m_last == 0) ? 1 : 0;
    end else if (p_req[0]) begin
      win = 0;
    end else if (p_req[1]) begin
      win = 1;
    end
    dut_win = bus.gnt1 ? 1 : (bus.gnt0 ? 0 : -1);
    chk("gnt0", bus.gnt0, 32'(win == 0));
    chk("gnt1", bus.gnt1, 32'(win == 1));
    if (win >= 0) begin
      a   = p_addr[win];
      bad = (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'h0);
      w   = int'(a[ADDR_W+1:2]);
      chk("ram_we", bus.ram_we, 32'(!bad && p_we[win]));
      if (!bad && p_we[win]) begin
        chk("ram_addr", 32'(bus.ram_addr), 32'(w));
        chk("ram_din", bus.ram_din, p_wdata[win]);
      end
      e.cyc  = cyc;
      e.port = win;
      e.err  = bad;
      e.rd   = !bad && !p_we[win];
      e.data = bad ? 32'h0 : ref_mem[w];
      if (!bad && p_we[win]) ref_mem[w] = p_wdata[win];
      if (bad || !p_we[win]) q.push_back(e);
      m_last = win;
    end else begin
      chk("ram_we_idle", bus.ram_we, 32'h0);
    end
    // Lock bookkeeping in terms of grants held so far
    if (m_owner < 0) begin
      if (win >= 0 && p_lock[win] && MAX_LOCK > 1) begin
        m_owner = win;
        m_held  = 1;
      end
    end else if (win < 0) begin
      m_owner = -1;
    end else begin
      m_held++;
      if (!p_lock[win] || m_held == MAX_LOCK) m_owner = -1;
    end
    m_win = win;
  endtask

  task automatic run_cycle();
    drive();
    @(negedge clk);
    model_eval();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_port(int p);
    int          r;
    logic [31:0] word;
    p_req[p]   = ($urandom_range(0, 3) != 0);
    p_we[p]    = 1'($urandom_range(0, 1));
    p_lock[p]  = ($urandom_range(0, 2) == 0);
    p_wdata[p] = $urandom;
    word       = 32'($urandom_range(0, 15)) << 2;
    r          = $urandom_range(0, 19);
    if (r == 0)      p_addr[p] = word | 32'($urandom_range(1, 3));
    else if (r == 1) p_addr[p] = word | (32'h0001_0000 << $urandom_range(0, 15));
    else             p_addr[p] = word;
  endtask

  initial begin
    for (int i = 0; i < NWORDS; i++) ref_mem[i] = init_val(i);

    // Reset: grants and outputs held low even with requests present
    set_port(0, 1, 1, 0, 32'h10, 32'hFFFF_0000);
    set_port(1, 1, 0, 1, 32'h14, 32'h0);
    drive();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", {bus.gnt1, bus.gnt0}, 32'h0);
    chk("rst_flags", {bus.rvalid1, bus.rvalid0, bus.err1, bus.err0, bus.ram_we}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_all();
    run_cycle();

    // Single read from port 0
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    run_cycle();
    chk("t1_gnt", 32'(dut_win), 32'h0);
    chk("t1_rvalid0", bus.rvalid0, 32'h1);
    chk("t1_rvalid1", bus.rvalid1, 32'h0);
    chk("t1_rdata", bus.rdata, 32'hDEAD_BEEF);
    idle_all();
    run_cycle();

    // Alternation with both ports requesting (port 1 served last beforehand)
    set_port(1, 1, 1, 0, 32'h0C, 32'h0BAD_CAFE);
    run_cycle();
    set_port(0, 1, 0, 0, 32'h14, 32'h0);
    set_port(1, 1, 0, 0, 32'h18, 32'h0);
    for (int k = 0; k < 8; k++) begin
      run_cycle();
      pat[k] = dut_win;
    end
    for (int k = 0; k < 8; k++) chk("alt_pattern", 32'(pat[k]), 32'(k % 2));
    idle_all();
    run_cycle();

    // Locked burst from port 1 capped at MAX_LOCK grants
    set_port(0, 1, 0, 0, 32'h30, 32'h0);
    run_cycle();
    set_port(1, 1, 1, 1, 32'h20, 32'h1234_5678);
    for (int k = 0; k < 5; k++) begin
      run_cycle();
      pat[k] = dut_win;
    end
    for (int k = 0; k < 5; k++) chk("lock_pattern", 32'(pat[k]), (k < 4) ? 32'h1 : 32'h0);
    idle_all();
    run_cycle();
    chk("lock_mem", mem[8], 32'h1234_5678);

    // Out-of-range and misaligned write is dropped with an error pulse
    set_port(0, 1, 1, 0, 32'h0001_0002, 32'hCAFE_F00D);
    run_cycle();
    chk("err_pulse", bus.err0, 32'h1);
    idle_all();
    run_cycle();
    chk("err_gone", bus.err0, 32'h0);
    chk("err_mem0", mem[0], 32'h1111_1111);

    // Write then read the same word back-to-back
    set_port(0, 1, 1, 0, 32'h40, 32'hA5A5_A5A5);
    run_cycle();
    set_port(0, 1, 0, 0, 32'h40, 32'h0);
    run_cycle();
    chk("raw_rvalid", bus.rvalid0, 32'h1);
    chk("raw_rdata", bus.rdata, 32'hA5A5_A5A5);
    idle_all();
    run_cycle();

    // Randomised traffic; a pending request is held until granted
    for (int i = 0; i < 400; i++) begin
      for (int p = 0; p < 2; p++) begin
        if (!p_req[p] || m_win == p) rand_port(p);
      end
      run_cycle();
    end
    idle_all();
    run_cycle();
    run_cycle();

    // Reset in the middle of a locked read burst from port 1
    set_port(1, 1, 0, 1, 32'h08, 32'h0);
    run_cycle();
    drive();
    @(negedge clk);
    model_eval();
    #1;
    rst = 1'b1;
    q.delete();
    m_owner = -1;
    m_last  = 1;
    m_held  = 0;
    #1;
    chk("mid_rst_rvalid1", bus.rvalid1, 32'h0);
    chk("mid_rst_gnt1", bus.gnt1, 32'h0);
    @(posedge clk);
    #1;
    chk("mid_rst_flags", {bus.rvalid1, bus.rvalid0, bus.err1, bus.err0}, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    set_port(0, 1, 0, 0, 32'h10, 32'h0);
    set_port(1, 1, 0, 1, 32'h08, 32'h0);
    run_cycle();
    chk("post_rst_winner", 32'(dut_win), 32'h0);
    idle_all();
    repeat (3) run_cycle();
    chk("queue_empty", 32'(q.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
